rect_fill_engine: RTL and testbench
===================================

RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

Interface
REQ-001 SHALL have parameter VGA_WIDTH, default 640, visible pixels per line.
REQ-002 SHALL have parameter VGA_HEIGHT, default 480, visible lines per frame.
REQ-003 SHALL have parameter VGA_COLOR_DEPTH, default 8, bits per colour channel.
REQ-004 SHALL have clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have cmd_valid_i  input  1  rectangle command present.
REQ-007 SHALL have cmd_ready_o  output  1  engine accepts a command this cycle.
REQ-008 SHALL have cmd_x0_i, cmd_x1_i  input  10 each  column corners.
REQ-009 SHALL have cmd_y0_i, cmd_y1_i  input  9 each  row corners.
REQ-010 SHALL have cmd_color_i  input  3*VGA_COLOR_DEPTH  fill colour, {R,G,B}.
REQ-011 SHALL have abort_i  input  1  terminate current fill.
REQ-012 SHALL have wr_en_o  output  1  framebuffer write strobe to the VGA block.
REQ-013 SHALL have wr_addr_o  output  19  linear pixel address, y*VGA_WIDTH+x.
REQ-014 SHALL have wr_data_o  output  3*VGA_COLOR_DEPTH  pixel colour.
REQ-015 SHALL have busy_o  output  1  command in progress; done_o  output  1  one-cycle completion pulse; err_o  output  1  one-cycle rejection pulse.

Function
REQ-016 SHALL implement FSM IDLE -> SETUP -> FILL -> DONE -> IDLE; cmd_ready_o=1 only in IDLE; busy_o=1 in SETUP, FILL, DONE.
REQ-017 SHALL capture corners and colour on the edge where cmd_valid_i & cmd_ready_o, entering SETUP.
REQ-018 SHALL, in SETUP (exactly 1 cycle), order corners so x0<=x1, y0<=y1 (swap when reversed) and register start address y0*VGA_WIDTH+x0.
REQ-019 SHALL, in FILL, assert wr_en_o every cycle, one pixel per cycle, row-major, x ascending then y ascending; first write in the second cycle after acceptance.
REQ-020 SHALL advance wr_addr_o by 1 within a row and, at x==x1, wrap x to x0 and set address to previous row base + VGA_WIDTH (no multiplier in FILL).
REQ-021 SHALL issue exactly (x1-x0+1)*(y1-y0+1) writes, then enter DONE; done_o=1 for one cycle in DONE, cycle after last write.
REQ-022 SHALL hold wr_data_o constant at the captured colour for the whole command.
REQ-023 SHALL deassert wr_en_o on the cycle after abort_i is sampled high in FILL and go to DONE (done_o pulses); abort_i ignored in other states.
REQ-024 SHALL keep wr_en_o=0 in IDLE, SETUP, DONE; commands presented while busy wait with cmd_ready_o=0 (no loss, no overlap).
REQ-025 SHALL never emit an address >= VGA_WIDTH*VGA_HEIGHT.

Reset
REQ-026 SHALL, on rst_n low (any state, incl. mid-FILL), immediately force: state IDLE, wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, done_o=0, err_o=0; cmd_ready_o=1 once rst_n high.
REQ-027 SHALL produce no write and no done_o for a command interrupted by reset.

Configuration
REQ-028 SHALL, with macro RECT_FILL_CLIP_EN defined, clamp in SETUP any x>VGA_WIDTH-1 to VGA_WIDTH-1 and y>VGA_HEIGHT-1 to VGA_HEIGHT-1, then fill normally.
REQ-029 SHALL, without RECT_FILL_CLIP_EN, on any out-of-range corner pulse err_o one cycle in SETUP, issue zero writes, no done_o, return to IDLE.

Verification
REQ-030 Single pixel (5,7)-(5,7), colour 0xFF0000 -> one write addr 4485 data 0xFF0000, done_o next cycle.
REQ-031 Rect (638,0)-(639,1) -> writes at 638,639,1278,1279 on consecutive cycles, then done_o.
REQ-032 Swapped (10,2)-(8,2) -> writes 1288,1289,1290.
REQ-033 (630,470)-(700,500): with RECT_FILL_CLIP_EN -> 100 writes, last addr 307199; without -> err_o pulse, zero writes.
REQ-034 Second cmd_valid_i held during busy -> cmd_ready_o=0 until IDLE, then accepted; rst_n low at 3rd write of (0,0)-(9,9) -> wr_en_o=0 same cycle, no done_o.
REQ-035 abort_i at 5th write of (0,0)-(9,9) -> exactly 5 writes (addrs 0-4), done_o next cycle after last write.

Source files
------------

// File: rtl/rect_fill_engine.sv
// rect_fill_engine
//
// Fills an axis-aligned rectangle in a linear framebuffer. Each pixel is
// written with the same colour, one pixel per clock, row-major. A command
// is accepted in IDLE, the corners are ordered and range-checked in SETUP,
// pixels are streamed out in FILL, and DONE pulses completion.
//
// Optional feature: define RECT_FILL_CLIP_EN to clamp out-of-range corners
// to the screen edge instead of rejecting the command with err_o.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   cmd_valid_i          rectangle command present
//   cmd_ready_o          engine accepts a command this cycle (IDLE only)
//   cmd_x0_i, cmd_x1_i   column corners (any order)
//   cmd_y0_i, cmd_y1_i   row corners (any order)
//   cmd_color_i          fill colour {R,G,B}
//   abort_i              terminate the current fill
//   wr_en_o              framebuffer write strobe
//   wr_addr_o            linear pixel address y*VGA_WIDTH+x
//   wr_data_o            pixel colour
//   busy_o               command in progress
//   done_o               one-cycle completion pulse
//   err_o                one-cycle rejection pulse
module rect_fill_engine #(
  parameter int VGA_WIDTH       = 640,
  parameter int VGA_HEIGHT      = 480,
  parameter int VGA_COLOR_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [9:0]                   cmd_x0_i,
  input  logic [9:0]                   cmd_x1_i,
  input  logic [8:0]                   cmd_y0_i,
  input  logic [8:0]                   cmd_y1_i,
  input  logic [3*VGA_COLOR_DEPTH-1:0] cmd_color_i,
  input  logic                         abort_i,
  output logic                         wr_en_o,
  output logic [18:0]                  wr_addr_o,
  output logic [3*VGA_COLOR_DEPTH-1:0] wr_data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam logic [9:0]  X_MAX       = 10'(VGA_WIDTH - 1);
  localparam logic [8:0]  Y_MAX       = 9'(VGA_HEIGHT - 1);
  localparam logic [18:0] LINE_STRIDE = 19'(VGA_WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  state_t state, state_next;

  logic [9:0]                   cap_x0, cap_x1;
  logic [8:0]                   cap_y0, cap_y1;
  logic [3*VGA_COLOR_DEPTH-1:0] color;

  logic [9:0]  x_lo, x_hi, x_cur;
  logic [8:0]  y_hi, y_cur;
  logic [18:0] row_base, addr;

  logic [9:0]  sx0, sx1, sx_lo, sx_hi;
  logic [8:0]  sy0, sy1, sy_lo, sy_hi;
  logic        corner_bad;
  logic [18:0] start_addr;
  logic        last_pixel;

`ifdef RECT_FILL_CLIP_EN
  // Out-of-range corners are pulled back to the last visible column/row.
  assign sx0        = (cap_x0 > X_MAX) ? X_MAX : cap_x0;
  assign sx1        = (cap_x1 > X_MAX) ? X_MAX : cap_x1;
  assign sy0        = (cap_y0 > Y_MAX) ? Y_MAX : cap_y0;
  assign sy1        = (cap_y1 > Y_MAX) ? Y_MAX : cap_y1;
  assign corner_bad = 1'b0;
`else
  // Any out-of-range corner rejects the whole command.
  assign sx0        = cap_x0;
  assign sx1        = cap_x1;
  assign sy0        = cap_y0;
  assign sy1        = cap_y1;
  assign corner_bad = (cap_x0 > X_MAX) || (cap_x1 > X_MAX) ||
                      (cap_y0 > Y_MAX) || (cap_y1 > Y_MAX);
`endif

  // Corners may arrive reversed; order them so the scan always ascends.
  assign sx_lo = (sx0 <= sx1) ? sx0 : sx1;
  assign sx_hi = (sx0 <= sx1) ? sx1 : sx0;
  assign sy_lo = (sy0 <= sy1) ? sy0 : sy1;
  assign sy_hi = (sy0 <= sy1) ? sy1 : sy0;

  // The only multiply in the design; it is used once per command in SETUP.
  assign start_addr = 19'(sy_lo) * LINE_STRIDE + 19'(sx_lo);

  assign last_pixel = (x_cur == x_hi) && (y_cur == y_hi);

  assign wr_addr_o = addr;
  assign wr_data_o = color;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Output decode from state so that an asynchronous reset drops the
  // write strobe and status flags in the same cycle it is asserted.
  always_comb begin
    state_next  = state;
    cmd_ready_o = 1'b0;
    busy_o      = 1'b0;
    wr_en_o     = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_next = SETUP;
      end
      SETUP: begin
        busy_o = 1'b1;
        if (corner_bad) begin
          err_o      = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = FILL;
        end
      end
      FILL: begin
        busy_o  = 1'b1;
        wr_en_o = 1'b1;
        if (abort_i || last_pixel) state_next = DONE;
      end
      DONE: begin
        busy_o     = 1'b1;
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on accept, set up the scan in SETUP, then walk the
  // rectangle using only adds. A row wrap jumps to the previous row base
  // plus one line stride.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_x0   <= '0;
      cap_x1   <= '0;
      cap_y0   <= '0;
      cap_y1   <= '0;
      color    <= '0;
      x_lo     <= '0;
      x_hi     <= '0;
      x_cur    <= '0;
      y_hi     <= '0;
      y_cur    <= '0;
      row_base <= '0;
      addr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            cap_x0 <= cmd_x0_i;
            cap_x1 <= cmd_x1_i;
            cap_y0 <= cmd_y0_i;
            cap_y1 <= cmd_y1_i;
            color  <= cmd_color_i;
          end
        end
        SETUP: begin
          // A rejected command leaves the address untouched so no
          // off-screen value ever reaches wr_addr_o.
          if (!corner_bad) begin
            x_lo     <= sx_lo;
            x_hi     <= sx_hi;
            y_hi     <= sy_hi;
            x_cur    <= sx_lo;
            y_cur    <= sy_lo;
            row_base <= start_addr;
            addr     <= start_addr;
          end
        end
        FILL: begin
          if (!abort_i && !last_pixel) begin
            if (x_cur == x_hi) begin
              x_cur    <= x_lo;
              y_cur    <= y_cur + 9'd1;
              row_base <= row_base + LINE_STRIDE;
              addr     <= row_base + LINE_STRIDE;
            end else begin
              x_cur <= x_cur + 10'd1;
              addr  <= addr + 19'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// tb_rect_fill_engine
//
// Scoreboard bench for rect_fill_engine. Each accepted command is expanded
// by a plain-arithmetic reference model into the list of expected events
// (writes with address/data, done or err pulses), each stamped with the
// cycle it must appear in. A separate monitor pops and compares whenever
// the engine raises wr_en_o, done_o or err_o.
//
// Honours RECT_FILL_CLIP_EN in the reference model so it can be built in
// either configuration.
module tb_rect_fill_engine;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int CD = 8;

  localparam int K_WR   = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int          kind;
    int          cyc;
    int          addr;
    logic [23:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [9:0]    cmd_x0_i = '0;
  logic [9:0]    cmd_x1_i = '0;
  logic [8:0]    cmd_y0_i = '0;
  logic [8:0]    cmd_y1_i = '0;
  logic [23:0]   cmd_color_i = '0;
  logic          abort_i = 1'b0;
  logic          wr_en_o;
  logic [18:0]   wr_addr_o;
  logic [23:0]   wr_data_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_count = 0;
  exp_t sb[$];

  rect_fill_engine #(
    .VGA_WIDTH(W),
    .VGA_HEIGHT(H),
    .VGA_COLOR_DEPTH(CD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_x0_i(cmd_x0_i),
    .cmd_x1_i(cmd_x1_i),
    .cmd_y0_i(cmd_y0_i),
    .cmd_y1_i(cmd_y1_i),
    .cmd_color_i(cmd_color_i),
    .abort_i(abort_i),
    .wr_en_o(wr_en_o),
    .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: clamp or reject, order corners, then enumerate the
  // rectangle row by row. abort_k >= 0 truncates the fill after that many
  // writes.
  task automatic modelCommand(input int x0, input int x1, input int y0, input int y1,
                              input logic [23:0] color, input int acc, input int abort_k);
    int   xa, xb, ya, yb, xl, xh, yl, yh, n;
    bit   bad;
    exp_t e;
    bad = 0;
`ifdef RECT_FILL_CLIP_EN
    xa = (x0 > W - 1) ? W - 1 : x0;
    xb = (x1 > W - 1) ? W - 1 : x1;
    ya = (y0 > H - 1) ? H - 1 : y0;
    yb = (y1 > H - 1) ? H - 1 : y1;
`else
    bad = (x0 > W - 1) || (x1 > W - 1) || (y0 > H - 1) || (y1 > H - 1);
    xa = x0; xb = x1; ya = y0; yb = y1;
`endif
    if (bad) begin
      e = '{kind: K_ERR, cyc: acc + 1, addr: 0, data: '0};
      sb.push_back(e);
      return;
    end
    xl = (xa < xb) ? xa : xb;
    xh = (xa < xb) ? xb : xa;
    yl = (ya < yb) ? ya : yb;
    yh = (ya < yb) ? yb : ya;
    n = 0;
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        if (abort_k < 0 || n < abort_k) begin
          e = '{kind: K_WR, cyc: acc + 2 + n, addr: y * W + x, data: color};
          sb.push_back(e);
          n++;
        end
      end
    end
    e = '{kind: K_DONE, cyc: acc + 2 + n, addr: 0, data: '0};
    sb.push_back(e);
  endtask

  // Presents a command, holds it until accepted, records the expected
  // response and optionally pulses abort during the abort_k-th write.
  task automatic applyStimulus(input int x0, input int x1, input int y0, input int y1,
                               input logic [23:0] color, input int abort_k,
                               output int acc);
    int t;
    logic [31:0] v;
    @(negedge clk);
    v = x0; cmd_x0_i = v[9:0];
    v = x1; cmd_x1_i = v[9:0];
    v = y0; cmd_y0_i = v[8:0];
    v = y1; cmd_y1_i = v[8:0];
    cmd_color_i = color;
    cmd_valid_i = 1'b1;
    t = 0;
    while (!cmd_ready_o && t < 5000) begin
      if (busy_o) checkOutput("ready_while_busy", {31'd0, cmd_ready_o}, 32'd0);
      @(negedge clk);
      t++;
    end
    if (!cmd_ready_o) begin
      checkOutput("accept_timeout", {31'd0, cmd_ready_o}, 32'd1);
      cmd_valid_i = 1'b0;
      acc = -1;
      return;
    end
    checkOutput("no_overlap", sb.size(), 32'd0);
    acc = cyc;
    modelCommand(x0, x1, y0, y1, color, acc, abort_k);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    if (abort_k > 0) begin
      while (cyc < acc + 1 + abort_k) @(negedge clk);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
    end
  endtask

  task automatic checkEvent(input int kind);
    exp_t e;
    checkOutput("event_expected", {31'd0, sb.size() > 0}, 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    checkOutput("event_kind", kind, e.kind);
    checkOutput("event_cycle", cyc, e.cyc);
    if (kind == K_WR) begin
      checkOutput("wr_addr", {13'd0, wr_addr_o}, e.addr);
      checkOutput("wr_data", {8'd0, wr_data_o}, {8'd0, e.data});
      checkOutput("addr_in_screen", {31'd0, int'(wr_addr_o) < W * H}, 32'd1);
    end
  endtask

  // Monitor: compares every presented output event against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en_o) checkEvent(K_WR);
      if (done_o) begin
        done_count++;
        checkEvent(K_DONE);
      end
      if (err_o) checkEvent(K_ERR);
    end
  end

  initial begin
    int acc;
    int dc;
    int t;
    int x0, x1, y0, y1;

    #12;
    checkOutput("reset_wr_en", {31'd0, wr_en_o}, 32'd0);
    checkOutput("reset_addr", {13'd0, wr_addr_o}, 32'd0);
    checkOutput("reset_data", {8'd0, wr_data_o}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("reset_done", {31'd0, done_o}, 32'd0);
    checkOutput("reset_err", {31'd0, err_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", {31'd0, cmd_ready_o}, 32'd1);

    $display("[TB] directed commands");
    applyStimulus(5, 5, 7, 7, 24'hFF0000, -1, acc);
    applyStimulus(638, 639, 0, 1, 24'h00A5C3, -1, acc);
    applyStimulus(10, 8, 2, 2, 24'h123456, -1, acc);
    applyStimulus(630, 700, 470, 500, 24'h0F0F0F, -1, acc);

    // Second command presented while the first is still filling.
    applyStimulus(0, 3, 0, 3, 24'hABCDEF, -1, acc);
    applyStimulus(2, 1, 2, 1, 24'h55AA55, -1, acc);

    // Abort during the fifth write.
    applyStimulus(0, 9, 0, 9, 24'h777777, 5, acc);

    // Reset during the third write.
    $display("[TB] reset mid-fill");
    applyStimulus(0, 9, 0, 9, 24'h3C3C3C, -1, acc);
    dc = done_count;
    t = 0;
    while (cyc < acc + 4 && t < 100) begin
      @(negedge clk);
      t++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_wr_en", {31'd0, wr_en_o}, 32'd0);
    checkOutput("midreset_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("midreset_addr", {13'd0, wr_addr_o}, 32'd0);
    checkOutput("midreset_data", {8'd0, wr_data_o}, 32'd0);
    checkOutput("midreset_done", {31'd0, done_o}, 32'd0);
    sb.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("midreset_ready", {31'd0, cmd_ready_o}, 32'd1);
    repeat (20) @(negedge clk);
    checkOutput("midreset_no_done", done_count, dc);

    $display("[TB] random commands");
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        x0 = $urandom_range(620, 639);
        x1 = $urandom_range(620, 1023);
        y0 = $urandom_range(465, 479);
        y1 = $urandom_range(465, 511);
      end else begin
        x0 = $urandom_range(0, 639);
        x1 = x0 + $urandom_range(0, 24) - 12;
        if (x1 < 0) x1 = 0;
        if (x1 > W - 1) x1 = W - 1;
        y0 = $urandom_range(0, 479);
        y1 = y0 + $urandom_range(0, 24) - 12;
        if (y1 < 0) y1 = 0;
        if (y1 > H - 1) y1 = H - 1;
      end
      applyStimulus(x0, x1, y0, y1, 24'($urandom), -1, acc);
    end

    t = 0;
    while (sb.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    checkOutput("drain_empty", sb.size(), 32'd0);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
